// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - gate request types shared by the sensor frontend and the parking controller
package parking_pkg;

   localparam int   SLOT_W    = 2;
   localparam int   NUM_SLOTS = 4;
   localparam logic REQ_ENTRY = 1'b0;
   localparam logic REQ_EXIT  = 1'b1;

   typedef struct packed {
      logic              is_exit;
      logic [SLOT_W-1:0] slot;
   } gate_req_t;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchroniser, symmetric debounce and rising-edge pulse for one beam sensor
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             rise_q,  rise_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // The counter only survives while the synchronised input disagrees with the accepted level;
   // the cycle it would reach DEBOUNCE_CYCLES the level flips instead.
   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/parking_sensor_frontend.sv
// rtl/parking_sensor_frontend.sv - conditions entry/exit beam sensors into a queued stream of gate requests
module parking_sensor_frontend
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          entry_raw,
   input  logic                          exit_raw,
   input  logic [SLOT_W-1:0]             exit_slot_raw,
   output logic                          req_valid,
   output logic                          req_is_exit,
   output logic [SLOT_W-1:0]             req_slot,
   input  logic                          req_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   logic entry_rise;
   logic exit_rise;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
      .clk    (clk),
      .reset  (reset),
      .raw_in (entry_raw),
      .rise   (entry_rise)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
      .clk    (clk),
      .reset  (reset),
      .raw_in (exit_raw),
      .rise   (exit_rise)
   );

   logic [SLOT_W-1:0] slot_sync1_q, slot_sync1_d;
   logic [SLOT_W-1:0] slot_sync2_q, slot_sync2_d;
   gate_req_t         mem_q [FIFO_DEPTH];
   gate_req_t         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        drop_count_q, drop_count_d;

   logic              pop;
   logic              full;
   logic              push_vld;
   logic              push_ok;
   logic              fresh_drop;
   gate_req_t         push_req;
   gate_req_t         head;

   always_comb begin
      slot_sync1_d = exit_slot_raw;
      slot_sync2_d = slot_sync1_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      pending_d    = pending_q;
      overflow_d   = 1'b0;
      drop_count_d = drop_count_q;
      push_vld     = 1'b0;
      push_req     = '{is_exit: REQ_ENTRY, slot: '0};
      fresh_drop   = 1'b0;

      pop  = (count_q != '0) && req_ready;
      full = (count_q == CNT_FULL);

      // One push per cycle: a parked entry goes first, then exit, then a fresh entry.
      if (pending_q) begin
         push_vld   = 1'b1;
         pending_d  = 1'b0;
         fresh_drop = entry_rise || exit_rise;
      end else if (exit_rise) begin
         push_vld  = 1'b1;
         push_req  = '{is_exit: REQ_EXIT, slot: slot_sync2_q};
         pending_d = entry_rise;
      end else if (entry_rise) begin
         push_vld = 1'b1;
      end

      push_ok = push_vld && (!full || pop);

      if (push_ok) begin
         mem_d[wr_ptr_q] = push_req;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push_ok && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CNT_W'(1);
      end

      if ((push_vld && !push_ok) || fresh_drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_sync1_q <= '0;
         slot_sync2_q <= '0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pending_q    <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         slot_sync1_q <= slot_sync1_d;
         slot_sync2_q <= slot_sync2_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Head fields are gated so every output reads 0 while the queue is empty.
   assign head        = mem_q[rd_ptr_q];
   assign req_valid   = (count_q != '0);
   assign req_is_exit = req_valid && head.is_exit;
   assign req_slot    = req_valid ? head.slot : '0;
   assign fifo_count  = count_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// tb/tb_parking_sensor_frontend.sv - self-checking bench for parking_sensor_frontend
module tb_parking_sensor_frontend;

   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_raw;
   logic       exit_raw;
   logic [1:0] exit_slot_raw;
   logic       req_valid;
   logic       req_is_exit;
   logic [1:0] req_slot;
   logic       req_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic [7:0] drop_count;

   int total = 0;
   int bad   = 0;

   parking_sensor_frontend #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .entry_raw     (entry_raw),
      .exit_raw      (exit_raw),
      .exit_slot_raw (exit_slot_raw),
      .req_valid     (req_valid),
      .req_is_exit   (req_is_exit),
      .req_slot      (req_slot),
      .req_ready     (req_ready),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      entry_raw = 1'b0;
      exit_raw = 1'b0;
      exit_slot_raw = 2'b00;
      req_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pop_one();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
   endtask

   // Raw high for hi edges then low for lo edges; req_ready high only at edge ready_at (0 = never).
   task automatic sensor_pulse(input bit en, input bit ex, input logic [1:0] slot,
                               input int hi, input int lo, input int ready_at, output int ovf_seen);
      ovf_seen = 0;
      exit_slot_raw = slot;
      entry_raw = en;
      exit_raw = ex;
      req_ready = (ready_at == 1);
      for (int i = 1; i <= hi + lo; i++) begin
         tick();
         if (overflow) ovf_seen++;
         req_ready = (ready_at != 0) && (i == ready_at - 1);
         if (i == hi) begin
            entry_raw = 1'b0;
            exit_raw = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      entry_raw = 1'b0;
      exit_raw = 1'b0;
      exit_slot_raw = 2'b11;
      req_ready = 1'b1;
      #1;
      total++;
      if ({req_valid, req_is_exit, req_slot, fifo_count, overflow, drop_count} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {req_valid, req_is_exit, req_slot, fifo_count, overflow, drop_count});
      end
      do_reset();
   endtask

   task automatic test_glitch();
      int seen;
      seen = 0;
      do_reset();
      entry_raw = 1'b1;
      tick();
      tick();
      entry_raw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (req_valid || fifo_count != 3'd0) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL glitch_ignored: %0d cycles with a request, expected 0", seen);
      end
   endtask

   task automatic test_entry_latency();
      do_reset();
      entry_raw = 1'b1;
      for (int e = 1; e <= D + 3; e++) begin
         tick();
         total++;
         if (req_valid !== (e >= D + 3)) begin
            bad++;
            $display("FAIL entry_latency edge %0d: req_valid=%b expected %b", e, req_valid, e >= D + 3);
         end
      end
      for (int e = D + 4; e <= 10; e++) tick();
      entry_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      total++;
      if ({req_is_exit, req_slot, fifo_count} !== {1'b0, 2'b00, 3'd1}) begin
         bad++;
         $display("FAIL entry_head: is_exit=%b slot=%0d count=%0d expected 0/0/1",
                  req_is_exit, req_slot, fifo_count);
      end
      pop_one();
      total++;
      if (req_valid !== 1'b0 || fifo_count !== 3'd0) begin
         bad++;
         $display("FAIL entry_pop: valid=%b count=%0d expected 0/0", req_valid, fifo_count);
      end
   endtask

   task automatic test_exit_slot();
      int ovf;
      do_reset();
      sensor_pulse(1'b0, 1'b1, 2'b01, 10, 10, 0, ovf);
      total++;
      if ({req_valid, req_is_exit, req_slot, fifo_count} !== {1'b1, 1'b1, 2'b01, 3'd1}) begin
         bad++;
         $display("FAIL exit_head: valid=%b is_exit=%b slot=%0d count=%0d expected 1/1/1/1",
                  req_valid, req_is_exit, req_slot, fifo_count);
      end
      pop_one();
   endtask

   task automatic test_simultaneous();
      int ovf;
      do_reset();
      sensor_pulse(1'b1, 1'b1, 2'b10, 10, 10, 0, ovf);
      total++;
      if ({fifo_count, req_is_exit, req_slot} !== {3'd2, 1'b1, 2'b10}) begin
         bad++;
         $display("FAIL simul_first: count=%0d is_exit=%b slot=%0d expected 2/1/2",
                  fifo_count, req_is_exit, req_slot);
      end
      pop_one();
      total++;
      if ({fifo_count, req_valid, req_is_exit, req_slot} !== {3'd1, 1'b1, 1'b0, 2'b00}) begin
         bad++;
         $display("FAIL simul_second: count=%0d valid=%b is_exit=%b slot=%0d expected 1/1/0/0",
                  fifo_count, req_valid, req_is_exit, req_slot);
      end
      pop_one();
      total++;
      if (fifo_count !== 3'd0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL simul_drain: count=%0d overflow=%b expected 0/0", fifo_count, overflow);
      end
   endtask

   task automatic test_overflow();
      int ovf;
      int ovf_sum;
      ovf_sum = 0;
      do_reset();
      for (int n = 0; n < 5; n++) begin
         sensor_pulse(1'b1, 1'b0, 2'b00, 8, 8, 0, ovf);
         ovf_sum += ovf;
      end
      total++;
      if (fifo_count !== 3'd4 || drop_count !== 8'd1 || ovf_sum !== 1) begin
         bad++;
         $display("FAIL overflow_drop: count=%0d drops=%0d pulses=%0d expected 4/1/1",
                  fifo_count, drop_count, ovf_sum);
      end
      sensor_pulse(1'b1, 1'b0, 2'b00, 8, 8, D + 2, ovf);
      total++;
      if (fifo_count !== 3'd4 || drop_count !== 8'd1 || ovf !== 0) begin
         bad++;
         $display("FAIL full_push_pop: count=%0d drops=%0d pulses=%0d expected 4/1/0",
                  fifo_count, drop_count, ovf);
      end
   endtask

   task automatic test_reset_mid();
      int ovf;
      int seen;
      seen = 0;
      do_reset();
      for (int n = 0; n < 3; n++) sensor_pulse(1'b1, 1'b0, 2'b00, 8, 8, 0, ovf);
      total++;
      if (fifo_count !== 3'd3) begin
         bad++;
         $display("FAIL mid_prefill: count=%0d expected 3", fifo_count);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (req_valid !== 1'b0 || fifo_count !== 3'd0) begin
         bad++;
         $display("FAIL mid_reset: valid=%b count=%0d expected 0/0", req_valid, fifo_count);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (req_valid || fifo_count != 3'd0 || overflow) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL post_reset_quiet: %0d active cycles, expected 0", seen);
      end
   endtask

   task automatic test_held_through_reset();
      reset = 1'b1;
      entry_raw = 1'b1;
      exit_raw = 1'b0;
      req_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      entry_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      total++;
      if (fifo_count !== 3'd1 || req_is_exit !== 1'b0) begin
         bad++;
         $display("FAIL held_reset: count=%0d is_exit=%b expected 1/0", fifo_count, req_is_exit);
      end
   endtask

   // Clean pulses: a rise first sampled at edge k becomes a push at edge k+D+2.
   task automatic test_random();
      int  q[$];
      int  pushes[$];
      bit  ev_en[int];
      bit  ev_ex[int];
      int  ev_slot[int];
      int  ent_t, ext_t, edge_no, drops_m, h, errs;
      bit  ent_lv, ext_lv, ovf_m;
      logic [1:0] slot;
      do_reset();
      ent_t = int'($urandom_range(1, 10));
      ext_t = int'($urandom_range(1, 10));
      ent_lv = 1'b0;
      ext_lv = 1'b0;
      slot = 2'b00;
      edge_no = 0;
      drops_m = 0;
      errs = 0;
      for (int c = 0; c < 1700; c++) begin
         ent_t--;
         if (ent_t <= 0) begin
            if (ent_lv) begin
               ent_lv = 1'b0;
               ent_t = int'($urandom_range(D + 2, 3 * D + 10));
            end else if (c < 1600) begin
               ent_lv = 1'b1;
               ent_t = int'($urandom_range(D + 2, 2 * D + 8));
               ev_en[edge_no + 1 + D + 2] = 1'b1;
            end
         end
         ext_t--;
         if (ext_t <= 0) begin
            if (ext_lv) begin
               ext_lv = 1'b0;
               ext_t = int'($urandom_range(D + 2, 3 * D + 10));
            end else if (c < 1600) begin
               ext_lv = 1'b1;
               ext_t = int'($urandom_range(D + 2, 2 * D + 8));
               slot = 2'($urandom_range(0, 3));
               ev_ex[edge_no + 1 + D + 2] = 1'b1;
               ev_slot[edge_no + 1 + D + 2] = int'(slot);
            end
         end
         entry_raw = ent_lv;
         exit_raw = ext_lv;
         exit_slot_raw = slot;
         req_ready = (c < 800) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
         tick();
         edge_no++;

         if (q.size() != 0 && req_ready) q.delete(0);
         pushes.delete();
         if (ev_ex.exists(edge_no)) pushes.push_back(4 + ev_slot[edge_no]);
         if (ev_en.exists(edge_no) && !ev_ex.exists(edge_no)) pushes.push_back(0);
         if (ev_en.exists(edge_no - 1) && ev_ex.exists(edge_no - 1)) pushes.push_back(0);
         ovf_m = 1'b0;
         foreach (pushes[i]) begin
            if (q.size() < DEPTH) q.push_back(pushes[i]);
            else begin
               ovf_m = 1'b1;
               if (drops_m < 255) drops_m++;
            end
         end

         h = (q.size() != 0) ? q[0] : 0;
         total++;
         if (req_valid !== (q.size() != 0) || fifo_count !== 3'(q.size()) ||
             req_is_exit !== h[2] || req_slot !== h[1:0] ||
             overflow !== ovf_m || drop_count !== 8'(drops_m)) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("FAIL random edge %0d: valid=%b cnt=%0d exit=%b slot=%0d ovf=%b drops=%0d expected %b/%0d/%b/%0d/%b/%0d",
                        edge_no, req_valid, fifo_count, req_is_exit, req_slot, overflow, drop_count,
                        q.size() != 0, q.size(), h[2], h[1:0], ovf_m, drops_m);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      entry_raw = 1'b0;
      exit_raw = 1'b0;
      exit_slot_raw = 2'b00;
      req_ready = 1'b0;
      test_reset();
      test_glitch();
      test_entry_latency();
      test_exit_slot();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      test_held_through_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
